// File: rtl/hack_vga_scanout.sv
// hack_vga_scanout: VGA timing plus word fetch and serialisation of the Hack screen buffer.
// The Hack window is centred; everything outside it is driven black.
module hack_vga_scanout #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_OFF    = 64,
  parameter int V_OFF    = 112,
  parameter int WIN_W    = 512,
  parameter int WIN_H    = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] vga_data,
  output logic [12:0] vga_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pixel,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] HS_B  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_E  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_WIN = 11'(H_OFF);
  localparam logic [10:0] H_FET = 11'(H_OFF - 2);
  localparam logic [10:0] H_LD  = 11'(H_OFF - 1);
  localparam logic [10:0] W_W   = 11'(WIN_W);
  localparam logic [9:0]  V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_B  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_E  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_WIN = 10'(V_OFF);
  localparam logic [9:0]  W_H   = 10'(WIN_H);

  logic [DW-1:0] div_q, div_d;
  logic [10:0]   h_q, h_d, col, fx, lx;
  logic [9:0]    v_q, v_d, row;
  logic [15:0]   word_q, word_d;
  logic [12:0]   addr_q, addr_d;
  logic          hs_q, hs_d, vs_q, vs_d, von_q, von_d, pix_q, pix_d, fs_q, fs_d;
  logic          tick, h_wrap, v_wrap, in_v, in_win, fetch, load, vis;

  always_comb begin
    tick   = div_q == DIV_MAX;
    div_d  = tick ? '0 : div_q + DW'(1);
    h_wrap = h_q == H_MAX;
    v_wrap = v_q == V_MAX;
    h_d    = tick ? (h_wrap ? '0 : h_q + 11'd1) : h_q;
    v_d    = (tick && h_wrap) ? (v_wrap ? '0 : v_q + 10'd1) : v_q;
    col    = h_q - H_WIN;
    row    = v_q - V_WIN;
    // Unsigned wrap makes positions left of the window compare as out of range.
    fx     = h_q - H_FET;
    lx     = h_q - H_LD;
    in_v   = row < W_H;
    in_win = in_v && col < W_W;
    fetch  = tick && in_v && fx < W_W && fx[3:0] == 4'd0;
    load   = tick && in_v && lx < W_W && lx[3:0] == 4'd0;
    addr_d = fetch ? 13'({row, 5'b0} + 15'(fx >> 4)) : addr_q;
    word_d = load ? vga_data : word_q;
    vis    = h_q < H_ACT && v_q < V_ACT;
    von_d  = tick ? vis : von_q;
    hs_d   = tick ? !(h_q >= HS_B && h_q < HS_E) : hs_q;
    vs_d   = tick ? !(v_q >= VS_B && v_q < VS_E) : vs_q;
    // Hack stores a set bit as black, leftmost pixel in bit 0.
    pix_d  = tick ? (vis && in_win && !word_q[col[3:0]]) : pix_q;
    fs_d   = tick && h_wrap && v_wrap;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      word_q <= '0;
      addr_q <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      von_q  <= 1'b0;
      pix_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      word_q <= word_d;
      addr_q <= addr_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      von_q  <= von_d;
      pix_q  <= pix_d;
      fs_q   <= fs_d;
    end
  end

  assign vga_addr    = addr_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = von_q;
  assign pixel       = pix_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_hack_vga_scanout.sv
// tb_hack_vga_scanout: directed checks of a shrunken raster (56x16 pixels, 32x4 Hack window).
// Pixel m of the raster is on the outputs from the 2m+2-th clock edge after reset release.
module tb_hack_vga_scanout;
  localparam int HT  = 56;
  localparam int VT  = 16;
  localparam int FRM = HT * VT;

  typedef struct {
    int f; int h; int v;
    logic von; logic hs; logic vs; logic pix; logic fs;
    int addr;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] vga_data, ram_q;
  logic [12:0] vga_addr;
  logic hsync, vsync, video_on, pixel, frame_start;
  int e;
  int n_cmp = 0;
  int n_bad = 0;
  int fs_cnt = 0;
  vec_t tv[$];

  always #5 clock = ~clock;

  hack_vga_scanout #(
    .CLK_DIV(2), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .H_OFF(4), .V_OFF(3), .WIN_W(32), .WIN_H(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .vga_data(vga_data), .vga_addr(vga_addr),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .pixel(pixel),
    .frame_start(frame_start)
  );

  always @(posedge clock or negedge reset_n)
    if (!reset_n) e <= 0;
    else e <= e + 1;

  // Synchronous-read buffer: word 0 = 0001, word 97 (row 3, word 1) = 8000.
  always @(posedge clock)
    ram_q <= vga_addr == 13'd0 ? 16'h0001 : vga_addr == 13'd97 ? 16'h8000 : 16'h0000;

  // From frame 1 on the buffer reads 0, except FFFF in the one clock before the load of row 1 word 0.
  assign vga_data = e == 2 * (FRM + 4 * HT + 3) + 1 ? 16'hFFFF : e >= 2 * FRM ? 16'h0000 : ram_q;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic wait_pix(input int m);
    for (int k = 0; k < 5000 && e != 2 * m + 2; k++) @(negedge clock);
    chk($sformatf("reach pixel %0d", m), e, 2 * m + 2);
  endtask

  function automatic vec_t mk(input int f, h, v, input logic von, hs, vs, pix, fs, input int addr);
    vec_t r;
    r.f = f; r.h = h; r.v = v; r.von = von; r.hs = hs; r.vs = vs; r.pix = pix; r.fs = fs; r.addr = addr;
    return r;
  endfunction

  always @(negedge clock)
    if (frame_start) begin
      fs_cnt++;
      chk("frame_start phase", e % (2 * FRM), 0);
    end

  initial begin
    int lows, first;
    //            f  h  v  von hs vs pix fs addr
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 39, 0, 1, 1, 1, 0, 0, -1));
    tv.push_back(mk(0, 40, 0, 0, 1, 1, 0, 0, -1));
    tv.push_back(mk(0, 43, 0, 0, 1, 1, 0, 0, -1));
    tv.push_back(mk(0, 44, 0, 0, 0, 1, 0, 0, -1));
    tv.push_back(mk(0, 49, 0, 0, 0, 1, 0, 0, -1));
    tv.push_back(mk(0, 50, 0, 0, 1, 1, 0, 0, -1));
    tv.push_back(mk(0, 4, 2, 1, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 3, 3, 1, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 4, 3, 1, 1, 1, 0, 0, 0));
    tv.push_back(mk(0, 5, 3, 1, 1, 1, 1, 0, -1));
    tv.push_back(mk(0, 17, 3, 1, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 18, 3, 1, 1, 1, 1, 0, 1));
    tv.push_back(mk(0, 19, 3, 1, 1, 1, 1, 0, -1));
    tv.push_back(mk(0, 20, 3, 1, 1, 1, 1, 0, -1));
    tv.push_back(mk(0, 35, 3, 1, 1, 1, 1, 0, -1));
    tv.push_back(mk(0, 36, 3, 1, 1, 1, 0, 0, -1));
    tv.push_back(mk(0, 2, 6, 1, 1, 1, 0, 0, 96));
    tv.push_back(mk(0, 20, 6, 1, 1, 1, 1, 0, -1));
    tv.push_back(mk(0, 34, 6, 1, 1, 1, 1, 0, -1));
    tv.push_back(mk(0, 35, 6, 1, 1, 1, 0, 0, 97));
    tv.push_back(mk(0, 4, 7, 1, 1, 1, 0, 0, 97));
    tv.push_back(mk(0, 0, 10, 0, 1, 1, 0, 0, -1));
    tv.push_back(mk(0, 0, 12, 0, 1, 0, 0, 0, -1));
    tv.push_back(mk(0, 55, 13, 0, 1, 0, 0, 0, -1));
    tv.push_back(mk(0, 0, 14, 0, 1, 1, 0, 0, -1));
    tv.push_back(mk(0, 55, 15, 0, 1, 1, 0, 1, 97));
    tv.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 97));
    tv.push_back(mk(1, 1, 3, 1, 1, 1, 0, 0, 97));
    tv.push_back(mk(1, 2, 3, 1, 1, 1, 0, 0, 0));
    tv.push_back(mk(1, 4, 3, 1, 1, 1, 1, 0, -1));
    tv.push_back(mk(1, 18, 3, 1, 1, 1, 1, 0, 1));
    tv.push_back(mk(1, 3, 4, 1, 1, 1, 0, 0, -1));
    tv.push_back(mk(1, 4, 4, 1, 1, 1, 0, 0, -1));
    tv.push_back(mk(1, 19, 4, 1, 1, 1, 0, 0, -1));
    tv.push_back(mk(1, 20, 4, 1, 1, 1, 1, 0, -1));
    tv.push_back(mk(1, 35, 4, 1, 1, 1, 1, 0, -1));
    tv.push_back(mk(1, 4, 5, 1, 1, 1, 1, 0, -1));

    repeat (3) @(negedge clock);
    chk("reset vga_addr", vga_addr, 0);
    chk("reset hsync", hsync, 1);
    chk("reset vsync", vsync, 1);
    chk("reset video_on", video_on, 0);
    chk("reset pixel", pixel, 0);
    chk("reset frame_start", frame_start, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("no tick after one clock", video_on, 0);

    foreach (tv[i]) begin
      wait_pix(tv[i].f * FRM + tv[i].v * HT + tv[i].h);
      chk($sformatf("v%0d(%0d,%0d) video_on", i, tv[i].h, tv[i].v), video_on, tv[i].von);
      chk($sformatf("v%0d(%0d,%0d) hsync", i, tv[i].h, tv[i].v), hsync, tv[i].hs);
      chk($sformatf("v%0d(%0d,%0d) vsync", i, tv[i].h, tv[i].v), vsync, tv[i].vs);
      chk($sformatf("v%0d(%0d,%0d) pixel", i, tv[i].h, tv[i].v), pixel, tv[i].pix);
      chk($sformatf("v%0d(%0d,%0d) frame_start", i, tv[i].h, tv[i].v), frame_start, tv[i].fs);
      if (tv[i].addr >= 0)
        chk($sformatf("v%0d(%0d,%0d) vga_addr", i, tv[i].h, tv[i].v), vga_addr, tv[i].addr);
    end

    lows = 0;
    first = -1;
    for (int h = 0; h < HT; h++) begin
      wait_pix(2 * FRM + HT + h);
      if (!hsync) begin
        lows++;
        if (first < 0) first = h;
      end
    end
    chk("hsync low ticks per line", lows, 6);
    chk("hsync first low column", first, 44);

    wait_pix(2 * FRM + 8 * HT + 30);
    chk("pre-reset video_on", video_on, 1);
    chk("pre-reset vga_addr", vga_addr, 97);
    #1 reset_n = 1'b0;
    #1;
    chk("async reset vga_addr", vga_addr, 0);
    chk("async reset video_on", video_on, 0);
    chk("async reset hsync", hsync, 1);
    chk("async reset vsync", vsync, 1);
    chk("async reset pixel", pixel, 0);
    chk("async reset frame_start", frame_start, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 2 * FRM + 100 && !frame_start; k++) @(negedge clock);
    chk("frame period after reset", e, 2 * FRM);
    @(negedge clock);
    chk("frame_start pulse count", fs_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
